// File: rtl/spike_event_merge_fifo_pkg.sv
`default_nettype none
// ============================================================================
// spike_event_merge_fifo_pkg
// Shared widths and event-record helpers for the multi-channel spike merge FIFO.
// Revision: 1.0
// ============================================================================
package spike_event_merge_fifo_pkg;

    localparam int BT_WIDTH_DEF     = 36;
    localparam int NEURON_WIDTH_DEF = 11;
    localparam int FIFO_WIDTH_DEF   = 11;
    localparam int BT_FRAC_BITS     = 4;
    localparam int EVT_WIDTH_DEF    = BT_WIDTH_DEF + NEURON_WIDTH_DEF;

    function automatic int evt_width(input int bt_w, input int nid_w);
        return bt_w + nid_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_event_chan_fifo.sv
`default_nettype none
// ============================================================================
// spike_event_chan_fifo
// One {BT, NID} event queue: storage, wrapping pointers, occupancy count.
// Revision: 1.0
// ============================================================================
module spike_event_chan_fifo
    import spike_event_merge_fifo_pkg::*;
#(
    parameter int BT_WIDTH     = BT_WIDTH_DEF,
    parameter int NEURON_WIDTH = NEURON_WIDTH_DEF,
    parameter int FIFO_WIDTH   = FIFO_WIDTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [BT_WIDTH-1:0]     bt_i,
    input  logic [NEURON_WIDTH-1:0] nid_i,
    output logic [BT_WIDTH-1:0]     head_bt_o,
    output logic [NEURON_WIDTH-1:0] head_nid_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [FIFO_WIDTH:0]     count_o
);

    localparam int EVT_W = evt_width(BT_WIDTH, NEURON_WIDTH);
    localparam int DEPTH = 2 ** FIFO_WIDTH;

    logic [EVT_W-1:0]      mem_q [DEPTH];
    logic [FIFO_WIDTH-1:0] wptr_q, wptr_d;
    logic [FIFO_WIDTH-1:0] rptr_q, rptr_d;
    logic [FIFO_WIDTH:0]   count_q, count_d;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (count_q == (FIFO_WIDTH+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A full channel still accepts a write when its head leaves in the same cycle.
    assign w_push = en_i && push_i && (!full_o || pop_i);
    assign w_pop  = en_i && pop_i && !empty_o;

    assign {head_bt_o, head_nid_o} = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_push) wptr_d = wptr_q + 1'b1;
        if (w_pop)  rptr_d = rptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wptr_q] <= {bt_i, nid_i};
    end

endmodule
`default_nettype wire

// File: rtl/spike_event_merge_fifo.sv
`default_nettype none
// ============================================================================
// spike_event_merge_fifo
// NUM_CH event queues merged into one BT-ordered dequeue stream.
// Optional drop counter: SPIKE_MERGE_DROP_COUNT_EN. Revision: 1.0
// ============================================================================
module spike_event_merge_fifo
    import spike_event_merge_fifo_pkg::*;
#(
    parameter int BT_WIDTH     = BT_WIDTH_DEF,
    parameter int FIFO_WIDTH   = FIFO_WIDTH_DEF,
    parameter int NEURON_WIDTH = NEURON_WIDTH_DEF,
    parameter int NUM_CH       = 4,
    parameter int CH_WIDTH     = 2,
    parameter int AF_LEVEL     = 2 ** FIFO_WIDTH - 4
) (
    input  logic                           Clock_i,
    input  logic                           Reset_i,
    input  logic                           QueueEnable_i,
    input  logic [NUM_CH-1:0]              Enqueue_i,
    input  logic [NUM_CH*BT_WIDTH-1:0]     BTIn_i,
    input  logic [NUM_CH*NEURON_WIDTH-1:0] NIDIn_i,
    input  logic                           Dequeue_i,
    output logic [BT_WIDTH-1:0]            BTOut_o,
    output logic [NEURON_WIDTH-1:0]        NIDOut_o,
    output logic [CH_WIDTH-1:0]            ChOut_o,
    output logic                           OutValid_o,
    output logic [BT_WIDTH-1:0]            BT_Head_o,
    output logic                           IsQueueEmpty_o,
    output logic [NUM_CH-1:0]              IsQueueFull_o,
`ifdef SPIKE_MERGE_DROP_COUNT_EN
    output logic [15:0]                    DropCount_o,
`endif
    output logic [NUM_CH-1:0]              AlmostFull_o
);

    logic [BT_WIDTH-1:0]     w_head_bt  [NUM_CH];
    logic [NEURON_WIDTH-1:0] w_head_nid [NUM_CH];
    logic [FIFO_WIDTH:0]     w_count    [NUM_CH];
    logic [NUM_CH-1:0]       w_full;
    logic [NUM_CH-1:0]       w_empty;
    logic [NUM_CH-1:0]       w_pop_vec;

    logic                    w_any;
    logic [CH_WIDTH-1:0]     w_sel;
    logic [BT_WIDTH-1:0]     w_min_bt;
    logic [NEURON_WIDTH-1:0] w_min_nid;
    logic                    w_pop_fire;

    logic [BT_WIDTH-1:0]     bt_out_q;
    logic [NEURON_WIDTH-1:0] nid_out_q;
    logic [CH_WIDTH-1:0]     ch_out_q;
    logic                    out_valid_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        assign w_pop_vec[c] = w_pop_fire && (w_sel == CH_WIDTH'(c));

        spike_event_chan_fifo #(
            .BT_WIDTH     (BT_WIDTH),
            .NEURON_WIDTH (NEURON_WIDTH),
            .FIFO_WIDTH   (FIFO_WIDTH)
        ) u_chan (
            .clk_i      (Clock_i),
            .rst_i      (Reset_i),
            .en_i       (QueueEnable_i),
            .push_i     (Enqueue_i[c]),
            .pop_i      (w_pop_vec[c]),
            .bt_i       (BTIn_i[c*BT_WIDTH +: BT_WIDTH]),
            .nid_i      (NIDIn_i[c*NEURON_WIDTH +: NEURON_WIDTH]),
            .head_bt_o  (w_head_bt[c]),
            .head_nid_o (w_head_nid[c]),
            .full_o     (w_full[c]),
            .empty_o    (w_empty[c]),
            .count_o    (w_count[c])
        );

        assign AlmostFull_o[c] = (w_count[c] >= (FIFO_WIDTH+1)'(AF_LEVEL));
    end

    // Strict less-than keeps the lowest channel index on BT ties.
    always_comb begin
        w_any     = 1'b0;
        w_sel     = '0;
        w_min_bt  = '0;
        w_min_nid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!w_empty[c] && (!w_any || (w_head_bt[c] < w_min_bt))) begin
                w_any     = 1'b1;
                w_sel     = CH_WIDTH'(c);
                w_min_bt  = w_head_bt[c];
                w_min_nid = w_head_nid[c];
            end
        end
    end

    assign w_pop_fire     = QueueEnable_i && Dequeue_i && w_any;
    assign BT_Head_o      = w_min_bt;
    assign IsQueueEmpty_o = &w_empty;
    assign IsQueueFull_o  = w_full;

    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            bt_out_q    <= '0;
            nid_out_q   <= '0;
            ch_out_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= w_pop_fire;
            if (w_pop_fire) begin
                bt_out_q  <= w_min_bt;
                nid_out_q <= w_min_nid;
                ch_out_q  <= w_sel;
            end
        end
    end

    assign BTOut_o    = bt_out_q;
    assign NIDOut_o   = nid_out_q;
    assign ChOut_o    = ch_out_q;
    assign OutValid_o = out_valid_q;

`ifdef SPIKE_MERGE_DROP_COUNT_EN
    logic [NUM_CH-1:0] w_drop;
    logic [4:0]        w_drop_n;
    logic [16:0]       w_drop_sum;
    logic [15:0]       drop_q, drop_d;

    assign w_drop = {NUM_CH{QueueEnable_i}} & Enqueue_i & w_full & ~w_pop_vec;

    always_comb begin
        w_drop_n = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_drop_n = w_drop_n + 5'(w_drop[c]);
        end
        w_drop_sum = {1'b0, drop_q} + 17'(w_drop_n);
        drop_d     = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) drop_q <= '0;
        else         drop_q <= drop_d;
    end

    assign DropCount_o = drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_event_merge_fifo.sv
`default_nettype none
// ============================================================================
// tb_spike_event_merge_fifo
// Self-checking bench: vector table, directed corner sequences, random traffic.
// ============================================================================
module tb_spike_event_merge_fifo;

    localparam int BTW   = 36;
    localparam int NW    = 11;
    localparam int FW    = 11;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int DEPTH = 2048;
    localparam int AF    = 2044;

    logic                clk = 1'b1;
    logic                rst = 1'b1;
    logic                en  = 1'b1;
    logic                deq = 1'b0;
    logic [NCH-1:0]      enq = '0;
    logic [NCH*BTW-1:0]  bt_in  = '0;
    logic [NCH*NW-1:0]   nid_in = '0;

    wire [BTW-1:0]  bt_out;
    wire [NW-1:0]   nid_out;
    wire [CHW-1:0]  ch_out;
    wire            out_valid;
    wire [BTW-1:0]  bt_head;
    wire            q_empty;
    wire [NCH-1:0]  q_full;
    wire [NCH-1:0]  q_af;
`ifdef SPIKE_MERGE_DROP_COUNT_EN
    wire [15:0]     drop_cnt;
`endif

    spike_event_merge_fifo #(
        .BT_WIDTH(BTW), .FIFO_WIDTH(FW), .NEURON_WIDTH(NW),
        .NUM_CH(NCH), .CH_WIDTH(CHW), .AF_LEVEL(AF)
    ) dut (
        .Clock_i        (clk),
        .Reset_i        (rst),
        .QueueEnable_i  (en),
        .Enqueue_i      (enq),
        .BTIn_i         (bt_in),
        .NIDIn_i        (nid_in),
        .Dequeue_i      (deq),
        .BTOut_o        (bt_out),
        .NIDOut_o       (nid_out),
        .ChOut_o        (ch_out),
        .OutValid_o     (out_valid),
        .BT_Head_o      (bt_head),
        .IsQueueEmpty_o (q_empty),
        .IsQueueFull_o  (q_full),
`ifdef SPIKE_MERGE_DROP_COUNT_EN
        .DropCount_o    (drop_cnt),
`endif
        .AlmostFull_o   (q_af)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: one queue per channel ----------------
    typedef struct {
        logic [BTW-1:0] bt;
        logic [NW-1:0]  nid;
    } ev_t;

    ev_t            q [NCH][$];
    logic [BTW-1:0] m_bt;
    logic [NW-1:0]  m_nid;
    logic [CHW-1:0] m_ch;
    logic           m_valid;
    int             m_drops;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_sel();
        int best = -1;
        for (int c = 0; c < NCH; c++)
            if (q[c].size() > 0 && (best < 0 || q[c][0].bt < q[best][0].bt)) best = c;
        return best;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) q[c].delete();
        m_bt = '0; m_nid = '0; m_ch = '0; m_valid = 1'b0; m_drops = 0;
    endtask

    // Pop is decided from the heads before this cycle's writes are applied.
    task automatic model_step();
        int  s;
        ev_t e;
        m_valid = 1'b0;
        if (!en) return;
        s = m_sel();
        if (deq && s >= 0) begin
            e = q[s].pop_front();
            m_bt = e.bt; m_nid = e.nid; m_ch = CHW'(s); m_valid = 1'b1;
        end
        for (int c = 0; c < NCH; c++) begin
            if (enq[c]) begin
                if (q[c].size() < DEPTH) begin
                    e.bt  = bt_in[c*BTW +: BTW];
                    e.nid = nid_in[c*NW +: NW];
                    q[c].push_back(e);
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0] ef, ea;
        logic [BTW-1:0] eh;
        int             s;
        for (int c = 0; c < NCH; c++) begin
            ef[c] = (q[c].size() == DEPTH);
            ea[c] = (q[c].size() >= AF);
        end
        s  = m_sel();
        eh = (s >= 0) ? q[s][0].bt : '0;
        chk("OutValid", 64'(out_valid), 64'(m_valid));
        chk("BTOut", 64'(bt_out), 64'(m_bt));
        chk("NIDOut", 64'(nid_out), 64'(m_nid));
        chk("ChOut", 64'(ch_out), 64'(m_ch));
        chk("IsQueueEmpty", 64'(q_empty), 64'(s < 0));
        chk("IsQueueFull", 64'(q_full), 64'(ef));
        chk("AlmostFull", 64'(q_af), 64'(ea));
        chk("BT_Head", 64'(bt_head), 64'(eh));
`ifdef SPIKE_MERGE_DROP_COUNT_EN
        chk("DropCount", 64'(drop_cnt), 64'(m_drops));
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ch(input int c, input logic [BTW-1:0] b, input logic [NW-1:0] n);
        bt_in[c*BTW +: BTW] = b;
        nid_in[c*NW +: NW]  = n;
    endtask

    // ---------------- merge vector table ----------------
    typedef struct {
        logic [NCH-1:0]          enq;
        logic [NCH-1:0][BTW-1:0] bt;
        logic                    deq;
        logic                    exp_valid;
        logic [BTW-1:0]          exp_bt;
        logic [CHW-1:0]          exp_ch;
        logic                    exp_empty;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{enq: 4'b1111, bt: {36'd5, 36'd1, 36'd5, 36'd3}, deq: 1'b0,
                   exp_valid: 1'b0, exp_bt: 36'd0, exp_ch: 2'd0, exp_empty: 1'b0};
        tbl[1] = '{enq: 4'b0001, bt: {36'd0, 36'd0, 36'd0, 36'd9}, deq: 1'b0,
                   exp_valid: 1'b0, exp_bt: 36'd0, exp_ch: 2'd0, exp_empty: 1'b0};
        tbl[2] = '{enq: 4'b0000, bt: '0, deq: 1'b1, exp_valid: 1'b1, exp_bt: 36'd1, exp_ch: 2'd2, exp_empty: 1'b0};
        tbl[3] = '{enq: 4'b0000, bt: '0, deq: 1'b1, exp_valid: 1'b1, exp_bt: 36'd3, exp_ch: 2'd0, exp_empty: 1'b0};
        tbl[4] = '{enq: 4'b0000, bt: '0, deq: 1'b1, exp_valid: 1'b1, exp_bt: 36'd5, exp_ch: 2'd1, exp_empty: 1'b0};
        tbl[5] = '{enq: 4'b0000, bt: '0, deq: 1'b1, exp_valid: 1'b1, exp_bt: 36'd5, exp_ch: 2'd3, exp_empty: 1'b0};
        tbl[6] = '{enq: 4'b0000, bt: '0, deq: 1'b1, exp_valid: 1'b1, exp_bt: 36'd9, exp_ch: 2'd0, exp_empty: 1'b1};
        tbl[7] = '{enq: 4'b0000, bt: '0, deq: 1'b1, exp_valid: 1'b0, exp_bt: 36'd9, exp_ch: 2'd0, exp_empty: 1'b1};

        model_reset();

        // Reset state
        #12;
        chk("rst_empty", 64'(q_empty), 64'd1);
        chk("rst_full", 64'(q_full), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_af", 64'(q_af), 64'd0);
        #3 rst = 1'b0;
        deq = 1'b1;
        cycle();
        chk("deq_on_empty_valid", 64'(out_valid), 64'd0);
        deq = 1'b0;

        // Cross-channel merge from the vector table
        for (int i = 0; i < 8; i++) begin
            enq    = tbl[i].enq;
            bt_in  = tbl[i].bt;
            nid_in = NCH*NW'($urandom);
            deq    = tbl[i].deq;
            cycle();
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].exp_valid));
            chk("tbl_bt", 64'(bt_out), 64'(tbl[i].exp_bt));
            chk("tbl_ch", 64'(ch_out), 64'(tbl[i].exp_ch));
            chk("tbl_empty", 64'(q_empty), 64'(tbl[i].exp_empty));
        end
        enq = '0; deq = 1'b0;

        // Fill ch1 to full, overflow once, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            enq = 4'b0010;
            set_ch(1, BTW'(i), NW'(i));
            cycle();
            chk("fill_af1", 64'(q_af[1]), 64'((i + 1) >= AF));
        end
        chk("fill_full1", 64'(q_full[1]), 64'd1);
        set_ch(1, 36'd4000, 11'd99);
        cycle();
        chk("overflow_full1", 64'(q_full[1]), 64'd1);
`ifdef SPIKE_MERGE_DROP_COUNT_EN
        chk("overflow_drop", 64'(drop_cnt), 64'd1);
`endif
        enq = '0; deq = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            chk("drain_nid", 64'(nid_out), 64'(i));
        end
        chk("drain_empty", 64'(q_empty), 64'd1);
        for (int k = 0; k < 20; k++) begin
            enq = 4'b0010; deq = 1'b0;
            set_ch(1, BTW'(5000 + k), NW'(17 + k));
            cycle();
            enq = '0; deq = 1'b1;
            cycle();
            chk("wrap_nid", 64'(nid_out), 64'(17 + k));
        end
        deq = 1'b0;

        // Full channel with simultaneous pop
        for (int i = 0; i < DEPTH; i++) begin
            enq = 4'b0001;
            set_ch(0, BTW'(100 + i), NW'(i));
            cycle();
        end
        set_ch(0, 36'd9000, 11'd7);
        deq = 1'b1;
        cycle();
        chk("fullpop_valid", 64'(out_valid), 64'd1);
        chk("fullpop_bt", 64'(bt_out), 64'd100);
        chk("fullpop_full", 64'(q_full[0]), 64'd1);
        enq = '0; deq = 1'b0;

        // Freeze
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enq = NCH'($urandom);
            deq = 1'($urandom);
            bt_in = NCH*BTW'({$urandom, $urandom, $urandom, $urandom, $urandom});
            cycle();
            chk("freeze_valid", 64'(out_valid), 64'd0);
            chk("freeze_full0", 64'(q_full[0]), 64'd1);
        end
        en = 1'b1; enq = '0;

        // Async reset mid-drain
        deq = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        #3 rst = 1'b1;
        model_reset();
        #2;
        check_all();
        chk("arst_empty", 64'(q_empty), 64'd1);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_bt", 64'(bt_out), 64'd0);
        #2 rst = 1'b0;
        deq = 1'b0; enq = 4'b0100;
        set_ch(2, 36'd7, 11'd5);
        cycle();
        enq = '0; deq = 1'b1;
        cycle();
        chk("post_rst_nid", 64'(nid_out), 64'd5);
        chk("post_rst_ch", 64'(ch_out), 64'd2);
        deq = 1'b0;

        // Randomised traffic with ties and occasional freeze
        for (int i = 0; i < 800; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            enq = NCH'($urandom);
            deq = ($urandom_range(0, 9) < 6);
            for (int c = 0; c < NCH; c++) set_ch(c, BTW'($urandom_range(0, 20)), NW'($urandom));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spike_event_merge_fifo.md
Name: spike_event_merge_fifo

Overview:
- Multi-channel successor to the single input spike FIFO.
- NUM_CH independent {BT, NID} event queues, each 2**FIFO_WIDTH deep, behind one dequeue port.
- Each dequeue returns the globally earliest binary-time event across all channel heads, so downstream neuron update logic consumes a single time-ordered spike stream.
- Sits between per-source spike input interfaces and the neuron scheduler.

Parameters:
- BT_WIDTH, 36, binary-time width; unsigned fixed point, 4 fractional bits.
- FIFO_WIDTH, 11, per-channel address width; depth = 2**FIFO_WIDTH.
- NEURON_WIDTH, 11, neuron ID width.
- NUM_CH, 4, number of input channels (1..16).
- CH_WIDTH, 2, width of the channel index; must be >= ceil(log2(NUM_CH)), minimum 1.
- AF_LEVEL, 2**FIFO_WIDTH-4, per-channel almost-full occupancy threshold.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- QueueEnable  input  1  global enable; when 0 all queue state is frozen.
- Enqueue  input  NUM_CH  per-channel write strobe.
- BTIn  input  NUM_CH*BT_WIDTH  flattened; channel c occupies bits [c*BT_WIDTH +: BT_WIDTH].
- NIDIn  input  NUM_CH*NEURON_WIDTH  flattened, same packing as BTIn.
- Dequeue  input  1  pop the earliest head event.
- BTOut  output  BT_WIDTH  registered BT of the last popped event.
- NIDOut  output  NEURON_WIDTH  registered NID of the last popped event.
- ChOut  output  CH_WIDTH  registered source channel of the last popped event.
- OutValid  output  1  one-cycle pulse; BTOut/NIDOut/ChOut are new this cycle.
- BT_Head  output  BT_WIDTH  combinational minimum BT over non-empty heads; 0 when all channels are empty.
- IsQueueEmpty  output  1  all channels empty.
- IsQueueFull  output  NUM_CH  per-channel full flag.
- AlmostFull  output  NUM_CH  per-channel flag, count >= AF_LEVEL.

Behaviour:
- Reset (asynchronous): all read/write pointers and counts = 0; BTOut, NIDOut, ChOut, OutValid = 0; IsQueueEmpty = 1; IsQueueFull = 0; AlmostFull = 0. Storage arrays are not reset. Reset asserted mid-operation discards all queued events immediately.
- Per channel: write pointer, read pointer (FIFO_WIDTH bits, natural wrap from 2**FIFO_WIDTH-1 to 0), count (FIFO_WIDTH+1 bits). Full when count == 2**FIFO_WIDTH; empty when count == 0.
- All updates occur on the rising edge and only when QueueEnable = 1. With QueueEnable = 0, strobes are ignored and OutValid = 0.
- Enqueue[c] on a non-full channel: write {BTIn_c, NIDIn_c} at wptr, increment wptr, increment count.
- Enqueue[c] on a full channel: event dropped, no state change. This holds unless the same channel is popped in the same cycle (see below).
- Selection: among non-empty channels, choose the minimum unsigned head BT. Ties resolve to the lowest channel index. Implemented as a combinational argmin over the heads.
- Dequeue with IsQueueEmpty = 0: on the next edge, selected head -> BTOut/NIDOut/ChOut, OutValid = 1, that channel's rptr increments and count decrements. Latency: data valid one cycle after the Dequeue edge.
- Dequeue with IsQueueEmpty = 1: ignored; OutValid = 0; output registers hold their previous value.
- Enqueue and pop on the same channel in one cycle: both occur and count is unchanged. This is legal even when the channel is full.
- Enqueue on an empty channel while Dequeue is asserted: the new event is not eligible for the pop in the same cycle; it becomes visible as a head next cycle.
- Dequeue held high drains one event per cycle in BT order across channels. Ordering within a channel is FIFO; cross-channel ordering is exact only when each channel is itself BT-monotonic.
- Flags IsQueueEmpty, IsQueueFull and AlmostFull derive combinationally from the count registers.

Optional Feature:
- Macro: SPIKE_MERGE_DROP_COUNT_EN.
- Defined: adds output DropCount (16 bits), which increments once per dropped enqueue (full channel, no same-cycle pop on that channel). Multiple channels dropping in the same cycle add their total. DropCount saturates at 16'hFFFF, resets to 0, and is frozen when QueueEnable = 0.
- Undefined: port absent; no counter logic.

Decomposition:
- Shared package: BT_WIDTH, NEURON_WIDTH and FIFO_WIDTH defaults; the BT fractional-bit constant (4); the event record {BT, NID} packing width.
- Sub-module spike_event_chan_fifo: single-channel storage, pointers and count, exposing head BT/NID, full, empty and count. Instantiated NUM_CH times in a generate loop.
- The top level holds the argmin selector, the output registers and the drop counter.

Test Plan:
- Reset state: Reset = 1 for 15 ns, QueueEnable = 1 -> IsQueueEmpty = 1, IsQueueFull = 0, OutValid = 0; a Dequeue pulse produces no OutValid.
- Cross-channel merge: ch0 BT = {3, 9}, ch1 BT = {5}, ch2 BT = {1}, ch3 BT = {5}, then hold Dequeue -> BTOut sequence 1, 3, 5, 5, 9; ChOut sequence 2, 0, 1, 3, 0; IsQueueEmpty = 1 after the 5th pop.
- Fill and wrap: 2048 enqueues on ch1 with NID = i -> IsQueueFull[1] = 1 and AlmostFull[1] = 1 from count 2044. The 2049th enqueue is dropped (DropCount = 1 when the macro is defined). Drain returns NID 0..2047 in order; then 20 interleaved enqueue/dequeue pairs return NIDs 17..36 across the pointer wrap.
- Full + simultaneous pop: ch0 full, its head is the minimum, Enqueue[0] and Dequeue asserted together -> event accepted, count stays 2048, OutValid = 1.
- Freeze: QueueEnable = 0 while strobes toggle for 10 cycles -> counts, pointers and outputs unchanged.
- Async reset mid-drain: Reset asserted between clock edges -> flags and outputs reach reset values before the next edge; subsequent enqueues start at pointer 0.
